cpu_bus_arbiter: RTL
====================

Name: cpu_bus_arbiter

Overview:
- Shares the single memory bus between the instruction-fetch port and the execute-stage data port.
- Latches one-cycle request pulses into per-port pending slots and grants one outstanding transaction at a time.
- Data has priority; a starvation counter guarantees fetch progress. Responses are routed back to the granted port.
- Sits between the CPU pipeline (fetch and execute stages) and the memory/peripheral interconnect.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT_CYCLES, 255: cycles to wait for m_ack before aborting. Used only with BUS_TIMEOUT_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_request  in  1  fetch request pulse (one cycle)
- i_addr  in  32  fetch word address
- i_ack  out  1  fetch response valid
- i_rdata  out  32  fetch read data
- d_request  in  1  data request pulse (one cycle)
- d_addr  in  32  data address
- d_write  in  1  1 = write
- d_byte_enable  in  4  write byte lanes
- d_wdata  in  32  write data
- d_size  in  2  00 = byte, 01 = half, 10 = word
- d_ack  out  1  data response valid
- d_rdata  out  32  data read data, raw 32-bit word
- d_busy  out  1  data transaction pending or in flight
- m_request  out  1  memory request pulse
- m_addr, m_write, m_byte_enable, m_wdata, m_size  out  32/1/4/32/2  registered copy of the granted request
- m_ack  in  1  memory response, one cycle
- m_rdata  in  32  memory read data
- bus_error  out  1  one-cycle pulse on aborted transaction
- protocol_error  out  1  sticky until reset

Behaviour:
- Reset (reset=0, async): state IDLE; pending slots empty; starve_cnt=0; owner=FETCH.
- Reset values: all outputs 0, including m_* fields and protocol_error.

Pending slots:
- A request pulse stores its fields into that port's slot and sets its pend flag on the next edge.
- A pulse on a port whose slot is already full, or whose transaction is in flight without ack this cycle, is dropped and sets protocol_error.
- A pulse in the same cycle as that port's ack is legal and is latched.
- Fetch-slot writes ignore the data-only fields.

State machine IDLE/BUSY:
- IDLE: if any pend flag is set, register the winner's fields onto m_*, pulse m_request for one cycle, clear the winner's pend, set owner, go BUSY.
- A request pulsed in cycle N is visible on m_request no earlier than N+2. Pulse at N → pend at N+1 → m_request at N+2.
- BUSY: wait for m_ack. m_ack is never expected in the same cycle as m_request. On m_ack, return to IDLE.
- Back-to-back: IDLE re-grants on the cycle after the ack. A full transaction occupies a minimum of 3 cycles: grant, ack, idle-grant.
- m_ack while IDLE is ignored and sets protocol_error.

Arbitration when both pend flags are set:
- Data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt increments on each data grant while fetch pend=1, saturating at STARVE_LIMIT.
- starve_cnt clears on any fetch grant, or whenever fetch pend=0.

Responses (combinational from m_ack):
- i_ack = m_ack & BUSY & owner==FETCH; d_ack likewise for DATA.
- i_rdata and d_rdata equal m_rdata when the matching ack is high, 0 otherwise.
- Write transactions also produce d_ack, with rdata don't-care.

d_busy = d_pend | (BUSY & owner==DATA).

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on grant and counts in BUSY.
  - When it reaches TIMEOUT_CYCLES without m_ack: return to IDLE, pulse bus_error for one cycle, and pulse the owner's ack with rdata=0.
  - A late m_ack arriving afterwards is ignored and sets protocol_error.
- Undefined: no counter; bus_error is tied to 0; BUSY waits indefinitely.

Test Plan:
- Reset mid-transaction: reset=0 while BUSY. Required: immediate m_request=0, state IDLE, both pend cleared. After reset=1, no ack is routed.
- Single fetch: i_request at cycle 10, i_addr=0x100; memory acks at cycle 14 with 0xDEADBEEF. Required: m_request at 12 with m_addr=0x100; i_ack=1 and i_rdata=0xDEADBEEF at 14; d_ack stays 0.
- Simultaneous requests: i_request and d_request in the same cycle, d_write=1, d_addr=0x2004, d_byte_enable=0011, d_wdata=0x1234. Required: data granted first with m_byte_enable=0011; fetch granted on the cycle after d_ack; d_busy falls after d_ack.
- Starvation: fetch held pending while data requests are re-issued on every d_ack (STARVE_LIMIT=4). Required: exactly 4 data grants, then a fetch grant, then starve_cnt=0.
- Protocol error: second d_request while d_pend=1. Required: request dropped, protocol_error=1 and stays 1 until reset. Separately, m_ack in IDLE also sets it.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8 and a memory that never acks a data read. Required: 8 cycles after the grant, bus_error and d_ack pulse once with d_rdata=0; state returns to IDLE; a pending fetch is granted next cycle.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one memory bus between the fetch and data ports, data first with fetch anti-starvation.
// Define BUS_TIMEOUT_EN to abort transactions that see no m_ack within TIMEOUT_CYCLES.
module cpu_bus_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_request,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_request,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic        m_request,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [3:0]  m_byte_enable,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        bus_error,
  output logic        protocol_error
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {FETCH, DATA} owner_t;
  state_t state;
  owner_t owner;
  logic i_pend, d_pend, d_write_q, timeout, done, i_drop, d_drop, grant_i, grant_d;
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic [3:0] d_be_q;
  logic [1:0] d_size_q;
  logic [SW-1:0] starve_cnt;
`ifdef BUS_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign timeout = state == BUSY && !m_ack && to_cnt == 16'(TIMEOUT_CYCLES);
  always_ff @(posedge clock or negedge reset)
    if (!reset) to_cnt <= '0;
    else if (grant_i || grant_d) to_cnt <= '0;
    else if (state == BUSY) to_cnt <= to_cnt + 16'd1;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif
  // a timeout completes the transaction like an ack, but with zero data
  assign done      = state == BUSY && (m_ack || timeout);
  assign i_ack     = done && owner == FETCH;
  assign d_ack     = done && owner == DATA;
  assign i_rdata   = (i_ack && m_ack) ? m_rdata : '0;
  assign d_rdata   = (d_ack && m_ack) ? m_rdata : '0;
  assign bus_error = timeout;
  assign d_busy    = d_pend || (state == BUSY && owner == DATA);
  assign i_drop    = i_pend || (state == BUSY && owner == FETCH && !i_ack);
  assign d_drop    = d_pend || (state == BUSY && owner == DATA && !d_ack);
  assign grant_d   = state == IDLE && d_pend && (!i_pend || starve_cnt != SW'(STARVE_LIMIT));
  assign grant_i   = state == IDLE && i_pend && !grant_d;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state          <= IDLE;
      owner          <= FETCH;
      i_pend         <= 1'b0;
      d_pend         <= 1'b0;
      i_addr_q       <= '0;
      d_addr_q       <= '0;
      d_write_q      <= 1'b0;
      d_be_q         <= '0;
      d_wdata_q      <= '0;
      d_size_q       <= '0;
      starve_cnt     <= '0;
      m_request      <= 1'b0;
      m_addr         <= '0;
      m_write        <= 1'b0;
      m_byte_enable  <= '0;
      m_wdata        <= '0;
      m_size         <= '0;
      protocol_error <= 1'b0;
    end else begin
      m_request <= 1'b0;
      if (grant_i) i_pend <= 1'b0;
      if (grant_d) d_pend <= 1'b0;
      if (i_request && !i_drop) begin
        i_pend   <= 1'b1;
        i_addr_q <= i_addr;
      end
      if (d_request && !d_drop) begin
        d_pend    <= 1'b1;
        d_addr_q  <= d_addr;
        d_write_q <= d_write;
        d_be_q    <= d_byte_enable;
        d_wdata_q <= d_wdata;
        d_size_q  <= d_size;
      end
      if ((i_request && i_drop) || (d_request && d_drop) || (state == IDLE && m_ack))
        protocol_error <= 1'b1;
      starve_cnt <= (!i_pend || grant_i) ? '0 :
                    (grant_d && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + SW'(1) : starve_cnt;
      if (grant_d) begin
        state         <= BUSY;
        owner         <= DATA;
        m_request     <= 1'b1;
        m_addr        <= d_addr_q;
        m_write       <= d_write_q;
        m_byte_enable <= d_be_q;
        m_wdata       <= d_wdata_q;
        m_size        <= d_size_q;
      end else if (grant_i) begin
        state         <= BUSY;
        owner         <= FETCH;
        m_request     <= 1'b1;
        m_addr        <= i_addr_q;
        m_write       <= 1'b0;
        m_byte_enable <= 4'hF;
        m_wdata       <= '0;
        m_size        <= 2'b10;
      end else if (done) state <= IDLE;
    end
endmodule
